// File: rtl/seq_match_logger.sv
// rtl/seq_match_logger.sv - match event counter with timestamp FIFO and valid/ready drain port

module seq_match_logger #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     det_in,
  input  logic                     enable,
  input  logic                     clr,
  output logic                     rd_valid,
  output logic [TS_W-1:0]          rd_data,
  input  logic                     rd_ready,
  output logic [CNT_W-1:0]         match_count,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [TS_W-1:0]  TS_ONE  = TS_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);

  // Free-running timestamp and saturating event count
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // FIFO pointers carry an extra wrap bit so full and empty are distinguishable
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [TS_W-1:0]  mem_q [DEPTH];

  // Registered read port; rd_data keeps its last value once the FIFO drains
  logic             rd_valid_q, rd_valid_d;
  logic [TS_W-1:0]  rd_data_q, rd_data_d;
  logic             ovf_q, ovf_d;

  logic             event_w;
  logic             pop_w;
  logic             full_w;
  logic             push_w;
  logic             drop_w;
  logic [AW-1:0]    wr_idx_w;

  assign wr_idx_w = wr_ptr_q[AW-1:0];
  assign full_w   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop in the same cycle frees the slot a full FIFO needs, so the push survives
  assign event_w = det_in & enable & ~clr;
  assign pop_w   = rd_valid_q & rd_ready & ~clr;
  assign push_w  = event_w & (~full_w | pop_w);
  assign drop_w  = event_w & full_w & ~pop_w;

  // Next-state for counters, pointers, flags and the registered head
  always_comb begin
    ts_d       = ts_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    ovf_d      = ovf_q;

    if (clr) begin
      ts_d       = '0;
      cnt_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      rd_valid_d = 1'b0;
      ovf_d      = 1'b0;
    end else begin
      if (enable) begin
        ts_d = ts_q + TS_ONE;
      end
      if (event_w && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end
      if (push_w) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop_w) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (drop_w) begin
        ovf_d = 1'b1;
      end

      level_d    = wr_ptr_d - rd_ptr_d;
      rd_valid_d = (level_d != '0);

      // The new head is either the value being written this cycle or an existing entry
      if (level_d != '0) begin
        if (push_w && (wr_idx_w == rd_ptr_d[AW-1:0])) begin
          rd_data_d = ts_q;
        end else begin
          rd_data_d = mem_q[rd_ptr_d[AW-1:0]];
        end
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_q       <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (push_w) begin
      mem_q[wr_idx_w] <= ts_q;
    end
  end

  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign match_count = cnt_q;
  assign fifo_level  = level_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_match_logger.sv
// tb/tb_seq_match_logger.sv - scoreboard bench for seq_match_logger

module tb_seq_match_logger;

  localparam int DEPTH   = 8;
  localparam int TS_W    = 4;
  localparam int CNT_W   = 6;
  localparam int LW      = $clog2(DEPTH) + 1;
  localparam int TS_MOD  = 1 << TS_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              det_in;
  logic              enable;
  logic              clr;
  logic              rd_ready;
  logic              rd_valid;
  logic [TS_W-1:0]   rd_data;
  logic [CNT_W-1:0]  match_count;
  logic [LW-1:0]     fifo_level;
  logic              overflow;

  seq_match_logger #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .det_in      (det_in),
    .enable      (enable),
    .clr         (clr),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_ready    (rd_ready),
    .match_count (match_count),
    .fifo_level  (fifo_level),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain counters and a queue standing in for the FIFO
  int m_ts  = 0;
  int m_cnt = 0;
  int m_ovf = 0;
  int m_fifo[$];
  // Scoreboard of timestamps the DUT must eventually present on its read port
  int sb_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_zero();
    m_ts  = 0;
    m_cnt = 0;
    m_ovf = 0;
    m_fifo.delete();
    sb_q.delete();
  endtask

  // Apply the rules for one clock edge using the inputs that edge sampled
  task automatic model_step();
    bit pop;
    bit ev;
    if (!reset) begin
      model_zero();
    end else if (clr) begin
      model_zero();
    end else begin
      pop = (m_fifo.size() > 0) && rd_ready;
      ev  = det_in && enable;
      if (pop) void'(m_fifo.pop_front());
      if (ev) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (m_fifo.size() < DEPTH) begin
          m_fifo.push_back(m_ts);
          sb_q.push_back(m_ts);
        end else begin
          m_ovf = 1;
        end
      end
      if (enable) m_ts = (m_ts + 1) % TS_MOD;
    end
  endtask

  // Monitor: compare flags every cycle and pop the scoreboard on each handshake
  always @(negedge clk) begin
    check("rd_valid", int'(rd_valid), int'(m_fifo.size() > 0));
    check("fifo_level", int'(fifo_level), m_fifo.size());
    check("match_count", int'(match_count), m_cnt);
    check("overflow", int'(overflow), m_ovf);
    if (rd_valid && rd_ready) begin
      if (sb_q.size() == 0) check("sb_underrun", 1, 0);
      else check("rd_data", int'(rd_data), sb_q.pop_front());
    end
  end

  // One clock: drive at posedge+2, let the edge happen, then advance the model
  task automatic cycle(input bit d, input bit e, input bit c, input bit r);
    det_in   = d;
    enable   = e;
    clr      = c;
    rd_ready = r;
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic run(input int n, input bit d, input bit e, input bit c, input bit r);
    for (int i = 0; i < n; i++) cycle(d, e, c, r);
  endtask

  // Asynchronous reset away from the clock edge; outputs must clear before any edge
  task automatic async_reset();
    reset = 1'b0;
    #1;
    check("arst_rd_valid", int'(rd_valid), 0);
    check("arst_rd_data", int'(rd_data), 0);
    check("arst_count", int'(match_count), 0);
    check("arst_level", int'(fifo_level), 0);
    check("arst_overflow", int'(overflow), 0);
    model_zero();
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    det_in   = 1'b0;
    enable   = 1'b0;
    clr      = 1'b0;
    rd_ready = 1'b0;
    #3;
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_count", int'(match_count), 0);
    check("rst_level", int'(fifo_level), 0);
    check("rst_overflow", int'(overflow), 0);
    @(posedge clk);
    #2;
    reset = 1'b1;

    // Events at ts=5 and ts=9, read back immediately
    for (int i = 0; i < 12; i++) cycle(i == 5 || i == 9, 1'b1, 1'b0, 1'b1);

    // Ten events into an eight-deep FIFO, then drain
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    run(10, 1'b1, 1'b1, 1'b0, 1'b0);
    run(10, 1'b0, 1'b1, 1'b0, 1'b1);

    // Full FIFO with simultaneous push and pop
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    run(8, 1'b1, 1'b1, 1'b0, 1'b0);
    run(4, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    run(10, 1'b0, 1'b1, 1'b0, 1'b1);

    // Events while disabled are ignored and the timestamp freezes
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    run(2, 1'b1, 1'b1, 1'b0, 1'b0);
    run(4, 1'b1, 1'b0, 1'b0, 1'b0);
    run(2, 1'b1, 1'b1, 1'b0, 1'b0);
    run(6, 1'b0, 1'b1, 1'b0, 1'b1);

    // Clear wins over a same-cycle event; the next event stamps ts=0
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    run(3, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    run(3, 1'b0, 1'b1, 1'b0, 1'b1);

    // Async reset with four stored entries, then timestamp wrap 15 -> 0
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    run(4, 1'b1, 1'b1, 1'b0, 1'b0);
    async_reset();
    for (int i = 0; i < 16; i++) cycle(i == 15, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    run(4, 1'b0, 1'b1, 1'b0, 1'b1);

    // Randomized traffic with alternating drain pressure to reach full/overflow/saturation
    for (int k = 0; k < 3000; k++) begin
      bit d;
      bit e;
      bit c;
      bit r;
      d = ($urandom_range(0, 2) != 0);
      e = ($urandom_range(0, 7) != 0);
      c = ($urandom_range(0, 299) == 0);
      if (((k / 150) % 2) == 0) r = ($urandom_range(0, 3) == 0);
      else                     r = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 999) == 0) async_reset();
      else cycle(d, e, c, r);
    end

    run(DEPTH + 2, 1'b0, 1'b0, 1'b0, 1'b1);
    check("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
